icu_wide: RTL and testbench
===========================

# icu_wide

Parametrised successor to the 1-bit instruction control unit: a `WIDTH`-bit, MC14500-style control sequencer with these parts:
- an internal program counter
- a return stack
- skip logic
- input/output enable gating
- a `WIDTH`-bit result register

It sits between a combinational program ROM (addressed by `pc`) and the I/O bus. It executes one 4-bit-opcode instruction per enabled clock.

## Interface
Parameters:
- `WIDTH`, 8: data and result register width (≥1).
- `PC_W`, 8: program counter width; instruction word is `4+PC_W` bits.
- `STACK_DEPTH`, 4: return stack entries (≥1, power of two).

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  execute enable; low = full stall.
- `instr`  in  `4+PC_W`  `{opcode[3:0], operand[PC_W-1:0]}` for the current `pc`; valid combinationally.
- `data_in`  in  `WIDTH`  input bus.
- `pc`  out  `PC_W`  program counter (registered).
- `data_out`  out  `WIDTH`  store data (registered).
- `write`  out  1  one-cycle store strobe.
- `rr`  out  `WIDTH`  result register.
- `flag_o`  out  1  one-cycle pulse on NOPO.
- `flag_f`  out  1  one-cycle pulse on NOPF.
- `err`  out  1  one-cycle pulse on stack overflow or underflow.

## Operation
- Effective data `D = IEN ? data_in : 0`. `IEN` and `OEN` are internal 1-bit registers.
- Opcodes, all bitwise over `WIDTH`:
  - 0 NOPO: pulse `flag_o`.
  - 1 LD: RR←D.
  - 2 LDC: RR←~D.
  - 3 AND: RR←RR&D.
  - 4 ANDC: RR←RR&~D.
  - 5 OR: RR←RR|D.
  - 6 ORC: RR←RR|~D.
  - 7 XNOR: RR←~(RR^D).
  - 8 STO: `data_out`←RR; `write`=OEN.
  - 9 STOC: `data_out`←~RR; `write`=OEN.
  - A IEN: IEN←`data_in[0]` (raw, not masked).
  - B OEN: OEN←`data_in[0]`.
  - C JMP: push pc+1, pc←operand.
  - D RTN: pop into pc, then skip the next instruction.
  - E SKZ: skip the next instruction if RR==0 (all bits).
  - F NOPF: pulse `flag_f`.
- Non-jump instructions: pc←pc+1 mod 2^PC_W. Address 2^PC_W−1 wraps to 0.
- Skip: the internal `skip` flag squashes the next executed instruction.
  - A squashed instruction changes no state and emits no pulses; pc←pc+1 only.
  - A squashed JMP or RTN does not jump and does not touch the stack.
  - Squashing clears `skip`.
- Stack is circular with pointer `sp` and count `cnt`.
  - JMP when full: overwrite the oldest entry; `cnt` stays at `STACK_DEPTH`; `err` pulses; the jump still happens.
  - RTN when empty: pc←pc+1, no skip, `err` pulses.
- Operand bits are ignored for all opcodes except JMP.
- `en`=0: pc, RR, IEN, OEN, stack, `skip` and `data_out` hold. `write`, `flag_o`, `flag_f` and `err` are 0.

## Timing
- Reset (rst high at a rising edge, overrides `en`):
  - pc=0, RR=0, `data_out`=0.
  - `write`=`flag_o`=`flag_f`=`err`=0.
  - IEN=1, OEN=1.
  - stack empty (sp=0, cnt=0), `skip`=0.
- Instruction at `pc` executes at the edge where `en`=1. The new pc is visible the next cycle, so throughput is 1 instruction/cycle with no branch penalty.
- `write`, `data_out`, `flag_o`, `flag_f` and `err` are registered. They appear the cycle after the executing edge and last exactly one cycle unless the next instruction re-asserts them.
- RR result is visible the cycle after execute. Back-to-back dependent ops use the updated RR (no hazard).
- IEN/OEN change affects the following instruction. STO immediately after OEN uses the new OEN.
- Reset mid-program: all state, including a pending skip and stack contents, is discarded on that edge.

## Test plan
- Reset then `en`=1, ROM `{1,x}` (LD) with `data_in`=8'hA5, then `{8,x}` (STO) → rr=8'hA5 after 1 cycle; `write`=1, `data_out`=8'hA5 one cycle after STO; pc sequence 0,1,2.
- IEN with `data_in[0]`=0, then LD with `data_in`=8'hFF → rr=0. OEN with 0, then STO → `write` stays 0 and `data_out` updates.
- LD 0, SKZ, LD 8'h3C, STO → LD 8'h3C squashed; stored value 0; pc advances through 0..3.
- JMP 8'h10 at pc=5; at 8'h10, RTN → pc 5→16→6 (skip); instruction at 6 is squashed; instruction at 7 executes.
- `STACK_DEPTH`+1 nested JMPs → `err` pulses on the last one only. Then `STACK_DEPTH`+1 RTNs → the final RTN pulses `err` and falls through to pc+1.
- Assert `en`=0 for 3 cycles mid-program, then `rst` during a pending skip → state frozen while stalled; reset values on the reset edge; first post-reset instruction is not squashed.

Source files
------------

// File: rtl/icu_wide.sv
// rtl/icu_wide.sv - WIDTH-bit MC14500-style control sequencer with return stack and skip logic
module icu_wide #(
    parameter int WIDTH       = 8,
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [4+PC_W-1:0]   instr,
    input  logic [WIDTH-1:0]    data_in,
    output logic [PC_W-1:0]     pc,
    output logic [WIDTH-1:0]    data_out,
    output logic                write,
    output logic [WIDTH-1:0]    rr,
    output logic                flag_o,
    output logic                flag_f,
    output logic                err
);

    // A single-entry stack still needs a one-bit pointer so the array index stays legal.
    localparam int SP_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);

    localparam logic [SP_W-1:0]  SP_LAST  = SP_W'(STACK_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STACK_DEPTH);

    localparam logic [3:0] OP_NOPO = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_LDC  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_ANDC = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_ORC  = 4'h6;
    localparam logic [3:0] OP_XNOR = 4'h7;
    localparam logic [3:0] OP_STO  = 4'h8;
    localparam logic [3:0] OP_STOC = 4'h9;
    localparam logic [3:0] OP_IEN  = 4'hA;
    localparam logic [3:0] OP_OEN  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_RTN  = 4'hD;
    localparam logic [3:0] OP_SKZ  = 4'hE;
    localparam logic [3:0] OP_NOPF = 4'hF;

    logic [3:0]       opcode;
    logic [PC_W-1:0]  operand;
    logic             ien;
    logic             oen;
    logic             skip;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] alu_rr;
    logic [PC_W-1:0]  pc_inc;

    // Return stack: sp is the next free slot; when full it also points at the oldest entry,
    // so a push in the full state naturally overwrites the oldest return address.
    logic [PC_W-1:0]  stack [STACK_DEPTH];
    logic [SP_W-1:0]  sp;
    logic [SP_W-1:0]  sp_inc;
    logic [SP_W-1:0]  sp_dec;
    logic [CNT_W-1:0] cnt;
    logic             stack_full;
    logic             stack_empty;

    assign opcode  = instr[4+PC_W-1:PC_W];
    assign operand = instr[PC_W-1:0];
    assign d       = ien ? data_in : '0;
    assign pc_inc  = pc + PC_W'(1);

    assign sp_inc      = (sp == SP_LAST) ? '0 : sp + SP_W'(1);
    assign sp_dec      = (sp == '0) ? SP_LAST : sp - SP_W'(1);
    assign stack_full  = (cnt == CNT_FULL);
    assign stack_empty = (cnt == '0);

    // Logic unit: next RR for the load/logic opcodes, current RR otherwise.
    always_comb begin
        alu_rr = rr;
        case (opcode)
            OP_LD:   alu_rr = d;
            OP_LDC:  alu_rr = ~d;
            OP_AND:  alu_rr = rr & d;
            OP_ANDC: alu_rr = rr & ~d;
            OP_OR:   alu_rr = rr | d;
            OP_ORC:  alu_rr = rr | ~d;
            OP_XNOR: alu_rr = ~(rr ^ d);
            default: alu_rr = rr;
        endcase
    end

    // Sequencer: reset, stall, squash and execute of the instruction at pc.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= '0;
            rr       <= '0;
            data_out <= '0;
            write    <= 1'b0;
            flag_o   <= 1'b0;
            flag_f   <= 1'b0;
            err      <= 1'b0;
            ien      <= 1'b1;
            oen      <= 1'b1;
            skip     <= 1'b0;
            sp       <= '0;
            cnt      <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else begin
            // Strobes are single-cycle; they are re-raised only by the executing instruction.
            write  <= 1'b0;
            flag_o <= 1'b0;
            flag_f <= 1'b0;
            err    <= 1'b0;
            if (en) begin
                if (skip) begin
                    // Squashed instruction: only advance past it.
                    pc   <= pc_inc;
                    skip <= 1'b0;
                end else begin
                    pc <= pc_inc;
                    case (opcode)
                        OP_NOPO: flag_o <= 1'b1;
                        OP_LD, OP_LDC, OP_AND, OP_ANDC,
                        OP_OR, OP_ORC, OP_XNOR: rr <= alu_rr;
                        OP_STO: begin
                            data_out <= rr;
                            write    <= oen;
                        end
                        OP_STOC: begin
                            data_out <= ~rr;
                            write    <= oen;
                        end
                        // Enable registers take the raw bus bit; IEN masking does not apply.
                        OP_IEN: ien <= data_in[0];
                        OP_OEN: oen <= data_in[0];
                        OP_JMP: begin
                            stack[sp] <= pc_inc;
                            sp        <= sp_inc;
                            pc        <= operand;
                            if (stack_full) begin
                                err <= 1'b1;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                        OP_RTN: begin
                            // Empty stack falls through to pc+1 without arming skip.
                            if (stack_empty) begin
                                err <= 1'b1;
                            end else begin
                                pc   <= stack[sp_dec];
                                sp   <= sp_dec;
                                cnt  <= cnt - CNT_W'(1);
                                skip <= 1'b1;
                            end
                        end
                        OP_SKZ:  skip   <= (rr == '0);
                        OP_NOPF: flag_f <= 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_icu_wide.sv
// tb/tb_icu_wide.sv - directed self-checking bench for icu_wide
module tb_icu_wide;

    localparam int WIDTH = 8;
    localparam int PC_W  = 8;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic [4+PC_W-1:0] instr;
    logic [WIDTH-1:0]  data_in;
    logic [PC_W-1:0]   pc;
    logic [WIDTH-1:0]  data_out;
    logic              write;
    logic [WIDTH-1:0]  rr;
    logic              flag_o;
    logic              flag_f;
    logic              err;

    logic [4+PC_W-1:0] rom  [256];
    logic [WIDTH-1:0]  dmem [256];

    int checks = 0;
    int errors = 0;

    icu_wide #(.WIDTH(WIDTH), .PC_W(PC_W), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en), .instr(instr), .data_in(data_in),
        .pc(pc), .data_out(data_out), .write(write), .rr(rr),
        .flag_o(flag_o), .flag_f(flag_f), .err(err)
    );

    always #5 clk = ~clk;

    // Combinational program ROM and per-address input bus value.
    assign instr   = rom[pc];
    assign data_in = dmem[pc];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] ins(input logic [3:0] op, input logic [7:0] opd);
        return {op, opd};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_rom();
        for (int i = 0; i < 256; i++) begin
            rom[i]  = ins(4'hF, 8'h00);
            dmem[i] = 8'h00;
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        en  = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        clr_rom();
        step();

        // Basic LD / STO and reset values
        rom[0] = ins(4'h1, 8'h00); dmem[0] = 8'hA5;
        rom[1] = ins(4'h8, 8'h00);
        rom[2] = ins(4'h0, 8'h00);
        reset_dut();
        check("rst_pc", pc, 0);
        check("rst_rr", rr, 0);
        check("rst_dout", data_out, 0);
        check("rst_strobes", {write, flag_o, flag_f, err}, 0);
        step();
        check("ld_rr", rr, 8'hA5);
        check("ld_pc", pc, 1);
        step();
        check("sto_pc", pc, 2);
        check("sto_write", write, 1);
        check("sto_dout", data_out, 8'hA5);
        step();
        check("nopo_write", write, 0);
        check("nopo_flag", flag_o, 1);
        step();
        check("nopf_flag", {flag_o, flag_f}, 2'b01);

        // IEN/OEN gating
        clr_rom();
        rom[0] = ins(4'hA, 8'h00); dmem[0] = 8'h00;
        rom[1] = ins(4'h1, 8'h00); dmem[1] = 8'hFF;
        rom[2] = ins(4'hB, 8'h00); dmem[2] = 8'h00;
        rom[3] = ins(4'hA, 8'h00); dmem[3] = 8'h01;
        rom[4] = ins(4'h1, 8'h00); dmem[4] = 8'h5A;
        rom[5] = ins(4'h8, 8'h00);
        rom[6] = ins(4'hB, 8'h00); dmem[6] = 8'h01;
        rom[7] = ins(4'h9, 8'h00);
        reset_dut();
        step(); step();
        check("ien0_rr", rr, 0);
        step(); step(); step();
        check("ien1_rr", rr, 8'h5A);
        step();
        check("oen0_write", write, 0);
        check("oen0_dout", data_out, 8'h5A);
        step(); step();
        check("stoc_write", write, 1);
        check("stoc_dout", data_out, 8'hA5);

        // Logic ops chain
        clr_rom();
        rom[0] = ins(4'h1, 8'h00); dmem[0] = 8'hC3;
        rom[1] = ins(4'h3, 8'h00); dmem[1] = 8'h0F;
        rom[2] = ins(4'h5, 8'h00); dmem[2] = 8'h30;
        rom[3] = ins(4'h7, 8'h00); dmem[3] = 8'h0F;
        rom[4] = ins(4'h4, 8'h00); dmem[4] = 8'h03;
        rom[5] = ins(4'h6, 8'h00); dmem[5] = 8'hF0;
        rom[6] = ins(4'h2, 8'h00); dmem[6] = 8'h0F;
        reset_dut();
        step(); check("op_ld", rr, 8'hC3);
        step(); check("op_and", rr, 8'h03);
        step(); check("op_or", rr, 8'h33);
        step(); check("op_xnor", rr, 8'hC3);
        step(); check("op_andc", rr, 8'hC0);
        step(); check("op_orc", rr, 8'hCF);
        step(); check("op_ldc", rr, 8'hF0);

        // SKZ taken and not taken
        clr_rom();
        rom[0] = ins(4'h1, 8'h00); dmem[0] = 8'h00;
        rom[1] = ins(4'hE, 8'h00);
        rom[2] = ins(4'h1, 8'h00); dmem[2] = 8'h3C;
        rom[3] = ins(4'h8, 8'h00);
        rom[4] = ins(4'h1, 8'h00); dmem[4] = 8'h81;
        rom[5] = ins(4'hE, 8'h00);
        rom[6] = ins(4'h1, 8'h00); dmem[6] = 8'h01;
        reset_dut();
        step(); step(); step();
        check("skz_pc", pc, 3);
        check("skz_squash_rr", rr, 0);
        step();
        check("skz_write", write, 1);
        check("skz_dout", data_out, 0);
        step(); step(); step();
        check("skz_nz_rr", rr, 8'h01);
        check("skz_nz_pc", pc, 7);

        // JMP / RTN with skip after return
        clr_rom();
        rom[5]    = ins(4'hC, 8'h10);
        rom[8'h10] = ins(4'hD, 8'h00);
        rom[6]    = ins(4'h1, 8'h00); dmem[6] = 8'hFF;
        rom[7]    = ins(4'h1, 8'h00); dmem[7] = 8'h11;
        reset_dut();
        for (int i = 0; i < 5; i++) step();
        check("pre_jmp_pc", pc, 5);
        step(); check("jmp_pc", pc, 8'h10);
        step(); check("rtn_pc", pc, 6);
        check("rtn_err", err, 0);
        step(); check("rtn_squash_pc", pc, 7);
        check("rtn_squash_rr", rr, 0);
        step(); check("after_squash_rr", rr, 8'h11);

        // Stack overflow then underflow
        clr_rom();
        rom[8'h00] = ins(4'hC, 8'h20);
        rom[8'h20] = ins(4'hC, 8'h30);
        rom[8'h30] = ins(4'hC, 8'h40);
        rom[8'h40] = ins(4'hC, 8'h50);
        rom[8'h50] = ins(4'hC, 8'h60);
        rom[8'h60] = ins(4'hD, 8'h00);
        rom[8'h51] = ins(4'h0, 8'h00);
        rom[8'h52] = ins(4'hD, 8'h00);
        rom[8'h41] = ins(4'h0, 8'h00);
        rom[8'h42] = ins(4'hD, 8'h00);
        rom[8'h31] = ins(4'h0, 8'h00);
        rom[8'h32] = ins(4'hD, 8'h00);
        rom[8'h21] = ins(4'h0, 8'h00);
        rom[8'h22] = ins(4'hD, 8'h00);
        rom[8'h23] = ins(4'h1, 8'h00); dmem[8'h23] = 8'h77;
        reset_dut();
        step(); check("jmp1_err", err, 0);
        step(); step();
        step(); check("jmp4_err", err, 0);
        check("jmp4_pc", pc, 8'h50);
        step(); check("jmp5_err", err, 1);
        check("jmp5_pc", pc, 8'h60);
        step(); check("rtn1_pc", pc, 8'h51);
        check("rtn1_err", err, 0);
        step(); check("sq_nopo_flag", flag_o, 0);
        step(); check("rtn2_pc", pc, 8'h41);
        step(); step(); check("rtn3_pc", pc, 8'h31);
        step(); step(); check("rtn4_pc", pc, 8'h21);
        check("rtn4_err", err, 0);
        step(); step(); check("rtn5_pc", pc, 8'h23);
        check("rtn5_err", err, 1);
        step(); check("uf_noskip_rr", rr, 8'h77);
        check("uf_err_clear", err, 0);

        // Stall, then reset with a pending skip
        clr_rom();
        rom[0] = ins(4'h1, 8'h00); dmem[0] = 8'h5A;
        rom[1] = ins(4'h0, 8'h00);
        rom[2] = ins(4'h1, 8'h00); dmem[2] = 8'h00;
        rom[3] = ins(4'hE, 8'h00);
        rom[4] = ins(4'h1, 8'h00); dmem[4] = 8'hFF;
        reset_dut();
        step();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", pc, 1);
            check("stall_rr", rr, 8'h5A);
            check("stall_flag", flag_o, 0);
        end
        en = 1'b1;
        step(); check("unstall_flag", flag_o, 1);
        step(); step();
        check("skip_pending_pc", pc, 4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_pc", pc, 0);
        check("midrst_rr", rr, 0);
        step();
        check("post_rst_rr", rr, 8'h5A);
        check("post_rst_pc", pc, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
